// File: rtl/muldiv_pkg.sv
// Shared encodings and helpers for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers: WIDTH cycles of
// shift-add or restoring division, one sign-fix cycle, then a Done pulse.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  input  logic             Flush,
  input  logic             HiWrite,
  input  logic             LoWrite,
  input  logic [WIDTH-1:0] WriteData,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CW = clog2(WIDTH);
  localparam int W2 = 2 * WIDTH;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic             div_q, div_d;
  logic [WIDTH-1:0] a_raw_q, a_raw_d;
  logic [WIDTH-1:0] b_mag_q, b_mag_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             div_zero_q, div_zero_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  // Operand conditioning for a new job: magnitudes plus result signs.
  logic             start_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    start_signed = op_is_signed(Op);
    a_neg        = start_signed & OperandA[WIDTH-1];
    b_neg        = start_signed & OperandB[WIDTH-1];
    a_mag        = a_neg ? -OperandA : OperandA;
    b_mag        = b_neg ? -OperandB : OperandB;
  end

  // One shared WIDTH+1-bit adder: adds the multiplicand or subtracts the divisor.
  logic [WIDTH:0] add_x, add_y, add_r;

  assign add_x = div_q ? acc_q[W2-1:WIDTH-1] : {1'b0, acc_q[W2-1:WIDTH]};
  assign add_y = div_q ? ~{1'b0, b_mag_q} : {1'b0, b_mag_q};
  assign add_r = add_x + add_y + {{WIDTH{1'b0}}, div_q};

  logic [W2-1:0] step_acc;

  always_comb begin
    step_acc = acc_q;
    if (div_q) begin
      // Negative trial difference means the divisor did not fit: keep remainder.
      if (add_r[WIDTH]) step_acc = {acc_q[W2-2:0], 1'b0};
      else              step_acc = {add_r[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else if (acc_q[0]) begin
      step_acc = {add_r, acc_q[WIDTH-1:1]};
    end else begin
      step_acc = {1'b0, acc_q[W2-1:1]};
    end
  end

  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] quot_fix, rem_fix, fix_hi, fix_lo;

  always_comb begin
    prod_fix = neg_res_q ? -acc_q : acc_q;
    quot_fix = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = neg_rem_q ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];
    fix_hi   = prod_fix[W2-1:WIDTH];
    fix_lo   = prod_fix[WIDTH-1:0];
    if (div_q) begin
      if (div_zero_q) begin
        fix_hi = a_raw_q;
        fix_lo = '1;
      end else begin
        fix_hi = rem_fix;
        fix_lo = quot_fix;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    div_d      = div_q;
    a_raw_d    = a_raw_q;
    b_mag_d    = b_mag_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;

    unique case (state_q)
      S_IDLE: begin
        if (HiWrite) hi_d = WriteData;
        if (LoWrite) lo_d = WriteData;
        if (Start && !Flush) begin
          state_d    = S_RUN;
          cnt_d      = CW'(WIDTH - 1);
          acc_d      = {{WIDTH{1'b0}}, a_mag};
          div_d      = op_is_div(Op);
          a_raw_d    = OperandA;
          b_mag_d    = b_mag;
          neg_res_d  = a_neg ^ b_neg;
          neg_rem_d  = a_neg & op_is_div(Op);
          div_zero_d = op_is_div(Op) && (OperandB == '0);
        end
      end
      S_RUN: begin
        if (Flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = step_acc;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == '0) state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (Flush) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
          hi_d    = fix_hi;
          lo_d    = fix_lo;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      div_q      <= 1'b0;
      a_raw_q    <= '0;
      b_mag_q    <= '0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      div_q      <= div_d;
      a_raw_q    <= a_raw_d;
      b_mag_q    <= b_mag_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign Busy    = (state_q == S_RUN) || (state_q == S_FIX);
  assign Done    = (state_q == S_DONE);
  assign DivZero = (state_q == S_DONE) && div_zero_q;
  assign Hi      = hi_q;
  assign Lo      = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: cycle-level reference model compared every cycle,
// directed literal cases, then randomized traffic with flushes and resets.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic          clk;
  logic          reset;
  logic          Start;
  logic [1:0]    Op;
  logic [W-1:0]  OperandA, OperandB, WriteData;
  logic          Flush, HiWrite, LoWrite;
  logic          Busy, Done, DivZero;
  logic [W-1:0]  Hi, Lo;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  muldiv_unit #(.WIDTH(W)) dut (
    .Clock(clk), .Reset(reset), .Start(Start), .Op(Op),
    .OperandA(OperandA), .OperandB(OperandB), .Flush(Flush),
    .HiWrite(HiWrite), .LoWrite(LoWrite), .WriteData(WriteData),
    .Busy(Busy), .Done(Done), .DivZero(DivZero), .Hi(Hi), .Lo(Lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result {divzero, hi, lo} from plain integer arithmetic.
  function automatic logic [64:0] ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    logic [63:0] qv, rv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      OP_MULTU: begin
        p = 64'(a) * 64'(b);
        return {1'b0, p};
      end
      OP_MULT: begin
        p = 64'(sa * sb);
        return {1'b0, p};
      end
      default: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        if (op == OP_DIVU) return {1'b0, a % b, a / b};
        q = sa / sb;
        r = sa % sb;
        qv = 64'(q);
        rv = 64'(r);
        return {1'b0, rv[31:0], qv[31:0]};
      end
    endcase
  endfunction

  // Model: job age in cycles since Start was accepted (0 = idle).
  int          m_age = 0;
  logic [31:0] m_hi = '0, m_lo = '0, r_hi = '0, r_lo = '0;
  logic        r_dz = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_age <= 0;
      m_hi  <= '0;
      m_lo  <= '0;
    end else if (m_age == 0) begin
      if (HiWrite) m_hi <= WriteData;
      if (LoWrite) m_lo <= WriteData;
      if (Start && !Flush) begin
        m_age <= 1;
        {r_dz, r_hi, r_lo} <= ref_op(Op, OperandA, OperandB);
      end
    end else if (m_age <= W + 1) begin
      if (Flush) m_age <= 0;
      else begin
        if (m_age == W + 1) begin
          m_hi <= r_hi;
          m_lo <= r_lo;
        end
        m_age <= m_age + 1;
      end
    end else begin
      m_age <= 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_busy", 64'(Busy), 64'(m_age >= 1 && m_age <= W + 1));
      chk("model_done", 64'(Done), 64'(m_age == W + 2));
      chk("model_divzero", 64'(DivZero), 64'((m_age == W + 2) && r_dz));
      chk("model_hi", 64'(Hi), 64'(m_hi));
      chk("model_lo", 64'(Lo), 64'(m_lo));
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    next_cycle();
    Start = 1'b1; Op = op; OperandA = a; OperandB = b;
    next_cycle();
    Start = 1'b0;
  endtask

  // Waits up to max negedges; n = negedge index where Done was seen, else -1.
  task automatic wait_done(input int max, output int n, output int busy_cnt);
    n = -1;
    busy_cnt = 0;
    for (int k = 1; k <= max && n < 0; k++) begin
      @(negedge clk);
      if (Busy) busy_cnt++;
      if (Done) n = k;
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input logic exp_dz);
    int n, bc;
    start_op(op, a, b);
    wait_done(40, n, bc);
    chk({name, "_done_cycle"}, 64'(n), 64'(W + 2));
    chk({name, "_busy_cycles"}, 64'(bc), 64'(W + 1));
    chk({name, "_hi"}, 64'(Hi), 64'(exp_hi));
    chk({name, "_lo"}, 64'(Lo), 64'(exp_lo));
    chk({name, "_divzero"}, 64'(DivZero), 64'(exp_dz));
    $display("op %s a=%h b=%h -> hi=%h lo=%h dz=%0b done_cycle=%0d", name, a, b, Hi, Lo, DivZero, n);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(15));
      4: return -32'($urandom_range(15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n, bc, done_cnt;
    reset = 1'b1; Start = 1'b0; Op = 2'b00; OperandA = '0; OperandB = '0;
    Flush = 1'b0; HiWrite = 1'b0; LoWrite = 1'b0; WriteData = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_hi", 64'(Hi), 64'h0);
    chk("reset_lo", 64'(Lo), 64'h0);
    chk("reset_busy", 64'(Busy), 64'h0);
    chk("reset_done", 64'(Done), 64'h0);
    chk("reset_divzero", 64'(DivZero), 64'h0);

    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("mult_neg", OP_MULT, -32'd3, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_op("div_neg", OP_DIV, -32'd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
    run_op("divu_zero", OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1);

    // Flush in cycle 10 of a run.
    start_op(OP_DIVU, 32'd100, 32'd7);
    repeat (9) next_cycle();
    Flush = 1'b1;
    next_cycle();
    Flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", 64'(Busy), 64'h0);
    chk("flush_hi", 64'(Hi), 64'd5);
    chk("flush_lo", 64'(Lo), 64'hFFFF_FFFF);
    wait_done(40, n, bc);
    chk("flush_no_done", 64'(n), -64'sd1);
    $display("op flush_run -> busy_after=%0d done_seen=%0d", bc, n);

    // Start while busy must be ignored.
    start_op(OP_MULTU, 32'd3, 32'd4);
    repeat (4) next_cycle();
    Start = 1'b1; Op = OP_MULTU; OperandA = 32'd9; OperandB = 32'd9;
    next_cycle();
    Start = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 70; k++) begin
      @(negedge clk);
      if (Done) done_cnt++;
    end
    chk("busy_start_done_count", 64'(done_cnt), 64'd1);
    chk("busy_start_lo", 64'(Lo), 64'd12);
    $display("op start_while_busy -> dones=%0d lo=%h", done_cnt, Lo);

    // Reset in cycle 15 of a run.
    start_op(OP_MULT, 32'd5, 32'd6);
    repeat (14) next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    chk("midrun_reset_hi", 64'(Hi), 64'h0);
    chk("midrun_reset_lo", 64'(Lo), 64'h0);
    chk("midrun_reset_busy", 64'(Busy), 64'h0);
    $display("op reset_midrun -> hi=%h lo=%h busy=%0b", Hi, Lo, Busy);

    // MTHI in IDLE.
    next_cycle();
    HiWrite = 1'b1; WriteData = 32'h1234;
    next_cycle();
    HiWrite = 1'b0;
    @(negedge clk);
    chk("mthi_hi", 64'(Hi), 64'h1234);
    $display("op mthi 00001234 -> hi=%h", Hi);

    // MTLO while busy is ignored.
    start_op(OP_MULTU, 32'd2, 32'd3);
    repeat (4) next_cycle();
    LoWrite = 1'b1; WriteData = 32'hDEAD_BEEF;
    next_cycle();
    LoWrite = 1'b0;
    @(negedge clk);
    chk("mtlo_busy_lo", 64'(Lo), 64'h0);
    wait_done(40, n, bc);
    chk("mtlo_busy_done_cycle", 64'(n), 64'd28);
    chk("mtlo_busy_result_lo", 64'(Lo), 64'd6);
    $display("op mtlo_while_busy -> lo=%h", Lo);

    // Randomized traffic, checked every cycle by the model.
    for (int c = 0; c < 4000; c++) begin
      next_cycle();
      reset     = ($urandom_range(699) == 0);
      Start     = ($urandom_range(2) == 0);
      Op        = 2'($urandom_range(3));
      OperandA  = pick();
      OperandB  = pick();
      Flush     = ($urandom_range(149) == 0);
      HiWrite   = ($urandom_range(9) == 0);
      LoWrite   = ($urandom_range(9) == 0);
      WriteData = $urandom;
      if (Done) $display("rand done hi=%h lo=%h dz=%0b", Hi, Lo, DivZero);
    end
    next_cycle();
    reset = 1'b0; Start = 1'b0; Flush = 1'b0; HiWrite = 1'b0; LoWrite = 1'b0;
    repeat (40) next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
